// File: rtl/flopr_vector_checker.sv
// Self-checking stimulus/response engine for the flopr reset register.
// Drives d/reset from a vector ROM, compares q one cycle later, records results.
module flopr_vector_checker #(
  parameter int N          = 64,
  parameter int NVEC       = 10,
  parameter int RST_CYCLES = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         dut_reset,
  output logic [N-1:0] d_out,
  input  logic [N-1:0] q_in,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [7:0]   err_count,
  output logic [7:0]   fail_idx,
  output logic [N-1:0] fail_q
);

  // state  | meaning
  // IDLE   | waiting for start, DUT held in reset
  // RST    | DUT reset held, q must read zero from the second cycle on
  // DRIVE  | ROM vectors driven, previous vector compared
  // LAST   | final vector held one more cycle for its compare
  // DONE   | results held until start or reset
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_DRIVE = 3'd2,
    S_LAST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int          CW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] RST_FIRST = CW'(RST_CYCLES - 1);
  localparam logic [7:0]  LAST_IDX  = 8'(NVEC - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] rst_left;
  logic [7:0]    idx;
  logic          run_start;
  logic          chk_en;
  logic [N-1:0]  chk_exp;
  logic [7:0]    chk_tag;
  logic          err_hit;

  function automatic logic [N-1:0] rom(input logic [7:0] i);
    logic [31:0] w;
    case (i)
      8'd0:    w = 32'h12345678;
      8'd1:    w = 32'h01ea7a55;
      8'd2:    w = 32'h00011001;
      8'd3:    w = 32'h69694200;
      8'd4:    w = 32'h48eaf54c;
      8'd5:    w = 32'h80ecd145;
      8'd6:    w = 32'h4132fe14;
      8'd7:    w = 32'hbbbaaa00;
      8'd8:    w = 32'habcdef01;
      8'd9:    w = 32'h6710345a;
      default: w = 32'h0;
    endcase
    return N'(w);
  endfunction

  assign run_start = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RST;
      S_RST:   if (rst_left == '0) state_nxt = S_DRIVE;
      S_DRIVE: if (idx == LAST_IDX) state_nxt = S_LAST;
      S_LAST:  state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RST;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dut_reset = 1'b1;
    d_out     = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_RST: begin
        d_out = '1;
        busy  = 1'b1;
      end
      S_DRIVE: begin
        dut_reset = 1'b0;
        d_out     = rom(idx);
        busy      = 1'b1;
      end
      S_LAST: begin
        dut_reset = 1'b0;
        d_out     = rom(LAST_IDX);
        busy      = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign pass = done && (err_count == 8'd0);

  // Phase counters: reset-cycle down-counter and ROM index.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rst_left <= '0;
      idx      <= '0;
    end else begin
      if (run_start) begin
        rst_left <= RST_FIRST;
        idx      <= '0;
      end else if (state == S_RST) begin
        if (rst_left != '0) rst_left <= rst_left - 1'b1;
      end else if (state == S_DRIVE) begin
        idx <= idx + 8'd1;
      end
    end
  end

  // The first RST cycle still shows whatever q held before the run.
  always_comb begin
    chk_en  = 1'b0;
    chk_exp = '0;
    chk_tag = '0;
    case (state)
      S_RST: begin
        chk_en  = (rst_left != RST_FIRST);
        chk_tag = 8'hFF;
      end
      S_DRIVE: begin
        chk_en  = (idx != 8'd0);
        chk_exp = rom(idx - 8'd1);
        chk_tag = idx - 8'd1;
      end
      S_LAST: begin
        chk_en  = 1'b1;
        chk_exp = rom(LAST_IDX);
        chk_tag = LAST_IDX;
      end
      default: ;
    endcase
  end

  assign err_hit = chk_en && (q_in != chk_exp);

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_count <= '0;
      fail_idx  <= '0;
      fail_q    <= '0;
    end else if (run_start) begin
      err_count <= '0;
      fail_idx  <= '0;
      fail_q    <= '0;
    end else if (err_hit) begin
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (err_count == 8'd0) begin
        fail_idx <= chk_tag;
        fail_q   <= q_in;
      end
    end
  end

endmodule
